nic_controller: RTL

Network interface controller between the processor pipeline's NIC port and a router's local port. Holds one input packet from the router and one output packet from the processor in single-entry channel buffers. Arbitrates each buffer between its processor side and its network side with full/empty status flags. The processor reaches the block through its 2-bit register address, and the block drives the pipeline's NIC read-data input.

---
 rtl/nic_controller.sv | 62 ++++++
 1 files changed

// File: rtl/nic_controller.sv
// nic_controller: single-entry input/output packet buffers between the processor NIC port and a router port (NIC_POLARITY_EN gates sends on the VC phase).
module nic_controller #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            adder_nic,
  input  logic                  nicEn,
  input  logic                  nicEnWr,
  input  logic [DATA_WIDTH-1:0] nic_dataIn,
  output logic [DATA_WIDTH-1:0] nic_dataOut,
  input  logic                  net_si,
  output logic                  net_ri,
  input  logic [DATA_WIDTH-1:0] net_di,
  output logic                  net_so,
  input  logic                  net_ro,
  output logic [DATA_WIDTH-1:0] net_do,
  input  logic                  net_polarity
);
  logic [DATA_WIDTH-1:0] in_buf_q, in_buf_d, out_buf_q, out_buf_d, dout_q, dout_d;
  logic                  in_full_q, in_full_d, out_full_q, out_full_d;
  logic                  rd, wr, in_acc, send;
  assign net_ri = !in_full_q;
`ifdef NIC_POLARITY_EN
  assign net_so = out_full_q && (out_buf_q[DATA_WIDTH-1] == net_polarity);
`else
  assign net_so = out_full_q;
`endif
  assign net_do      = out_buf_q;
  assign nic_dataOut = dout_q;
  assign rd     = nicEn && !nicEnWr;
  assign wr     = nicEn && nicEnWr && adder_nic == 2'b10 && !out_full_q;
  assign in_acc = net_si && net_ri;
  assign send   = net_so && net_ro;
  // Status reads sample the pre-edge flags; buffer reads may return stale data.
  always_comb begin
    in_buf_d   = in_acc ? net_di : in_buf_q;
    in_full_d  = in_acc ? 1'b1 : (rd && adder_nic == 2'b00) ? 1'b0 : in_full_q;
    out_buf_d  = wr ? nic_dataIn : out_buf_q;
    out_full_d = send ? 1'b0 : wr ? 1'b1 : out_full_q;
    dout_d     = !rd                  ? dout_q :
                 adder_nic == 2'b00   ? in_buf_q :
                 adder_nic == 2'b01   ? {{(DATA_WIDTH-1){1'b0}}, in_full_q} :
                 adder_nic == 2'b11   ? {{(DATA_WIDTH-1){1'b0}}, out_full_q} :
                                        '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_buf_q   <= '0;
      out_buf_q  <= '0;
      dout_q     <= '0;
      in_full_q  <= 1'b0;
      out_full_q <= 1'b0;
    end else begin
      in_buf_q   <= in_buf_d;
      out_buf_q  <= out_buf_d;
      dout_q     <= dout_d;
      in_full_q  <= in_full_d;
      out_full_q <= out_full_d;
    end
  end
endmodule
